// File: rtl/bist_datapath_if.sv
// Controller/memory bus seen by the BIST datapath stage.
// The controller and the memory model drive through master; the datapath attaches as slave.
interface bist_datapath_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              enable;
    logic              up_down;
    logic              rst_adr;
    logic              pr_res_adr;
    logic              wr_en;
    logic              read_en;
    logic              data_bit;
    logic              clr_err;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic              c_out;
    logic              error;
    logic [ADDR_W-1:0] fail_addr;
    logic [7:0]        fail_cnt;
    logic              busy;

    modport master (
        output enable, up_down, rst_adr, pr_res_adr, wr_en, read_en, data_bit, clr_err, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, c_out, error, fail_addr, fail_cnt, busy
    );

    modport slave (
        input  enable, up_down, rst_adr, pr_res_adr, wr_en, read_en, data_bit, clr_err, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, c_out, error, fail_addr, fail_cnt, busy
    );
endinterface

// File: rtl/bist_datapath.sv
// Memory-BIST datapath: address counter, write-data generation, read-latency-matched
// compare pipeline and first-fail capture.
module bist_datapath #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    bist_datapath_if.slave  bus
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] adr_q [RD_LAT];
    logic [ADDR_W-1:0] adr_d [RD_LAT];
    logic              error_q, error_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [7:0]        fail_cnt_q, fail_cnt_d;
    logic              mismatch;

    always_comb begin
        addr_d = addr_q;
        if (bus.rst_adr) begin
            addr_d = '0;
        end else if (bus.pr_res_adr) begin
            addr_d = '1;
        end else if (bus.enable) begin
            addr_d = bus.up_down ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
        end
    end

    // Stage 0 captures every edge; entries keep moving even when enable drops.
    always_comb begin
        vld_d[0] = bus.mem_re;
        exp_d[0] = bus.data_bit;
        adr_d[0] = addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            exp_d[i] = exp_q[i-1];
            adr_d[i] = adr_q[i-1];
        end
    end

    assign mismatch = vld_q[RD_LAT-1] &&
                      (bus.mem_rdata != {DATA_W{exp_q[RD_LAT-1]}});

    // A clear at the same edge as a mismatch wins; that mismatch is dropped.
    always_comb begin
        error_d     = error_q;
        fail_addr_d = fail_addr_q;
        fail_cnt_d  = fail_cnt_q;
        if (bus.clr_err) begin
            error_d     = 1'b0;
            fail_addr_d = '0;
            fail_cnt_d  = '0;
        end else if (mismatch) begin
            error_d = 1'b1;
            if (!error_q) begin
                fail_addr_d = adr_q[RD_LAT-1];
            end
            if (fail_cnt_q != 8'hFF) begin
                fail_cnt_d = fail_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            vld_q       <= '0;
            exp_q       <= '0;
            error_q     <= 1'b0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                adr_q[i] <= '0;
            end
        end else begin
            addr_q      <= addr_d;
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            error_q     <= error_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
            for (int i = 0; i < RD_LAT; i++) begin
                adr_q[i] <= adr_d[i];
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = {DATA_W{bus.data_bit}};
    assign bus.mem_we    = bus.wr_en & bus.enable;
    assign bus.mem_re    = bus.read_en & bus.enable;
    assign bus.c_out     = bus.enable & ((bus.up_down & (&addr_q)) |
                                         (!bus.up_down & (addr_q == '0)));
    assign bus.error     = error_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.fail_cnt  = fail_cnt_q;
    assign bus.busy      = |vld_q;
endmodule

// File: tb/tb_bist_datapath.sv
// Scoreboard bench for bist_datapath: two instances (read latency 1 and 3) share the
// controller strobes; each has its own memory model with injectable bit faults.
module tb_bist_datapath;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bist_datapath_if #(.ADDR_W(4), .DATA_W(8)) b1 ();
    bist_datapath_if #(.ADDR_W(4), .DATA_W(8)) b3 ();

    bist_datapath #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    bist_datapath #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Memory models: registered reads, delayed to each instance's latency.
    logic [7:0]  mem1 [16];
    logic [7:0]  mem3 [16];
    logic [7:0]  rd1;
    logic [7:0]  rd3 [3];
    logic [15:0] bad1 = '0;
    logic [15:0] bad3 = '0;

    always @(posedge clk) begin
        if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
        if (b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
        rd1    <= mem1[b1.mem_addr] ^ (bad1[b1.mem_addr] ? 8'h10 : 8'h00);
        rd3[0] <= mem3[b3.mem_addr] ^ (bad3[b3.mem_addr] ? 8'h10 : 8'h00);
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign b1.mem_rdata = rd1;
    assign b3.mem_rdata = rd3[2];

    localparam int S_ADDR = 0, S_WE = 1, S_RE = 2, S_COUT = 3, S_ERR = 4,
                   S_FADDR = 5, S_FCNT = 6, S_BUSY = 7, S_WDATA = 8;

    typedef struct {
        int    cyc;
        int    dut;
        int    sig;
        int    exp;
        string name;
    } chk_t;

    chk_t sbq[$];
    int   cyc_cnt = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int val(input int d, input int s);
        if (d == 1) begin
            case (s)
                S_ADDR:  return int'(b1.mem_addr);
                S_WE:    return int'(b1.mem_we);
                S_RE:    return int'(b1.mem_re);
                S_COUT:  return int'(b1.c_out);
                S_ERR:   return int'(b1.error);
                S_FADDR: return int'(b1.fail_addr);
                S_FCNT:  return int'(b1.fail_cnt);
                S_BUSY:  return int'(b1.busy);
                default: return int'(b1.mem_wdata);
            endcase
        end
        case (s)
            S_ADDR:  return int'(b3.mem_addr);
            S_WE:    return int'(b3.mem_we);
            S_RE:    return int'(b3.mem_re);
            S_COUT:  return int'(b3.c_out);
            S_ERR:   return int'(b3.error);
            S_FADDR: return int'(b3.fail_addr);
            S_FCNT:  return int'(b3.fail_cnt);
            S_BUSY:  return int'(b3.busy);
            default: return int'(b3.mem_wdata);
        endcase
    endfunction

    // Monitor: checks every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        for (int i = 0; i < sbq.size(); ) begin
            if (sbq[i].cyc == cyc_cnt) begin
                int got;
                got = val(sbq[i].dut, sbq[i].sig);
                tests_run++;
                if (got != sbq[i].exp) begin
                    tests_failed++;
                    $display("FAIL %s (dut%0d, cycle %0d): got %0d, expected %0d",
                             sbq[i].name, sbq[i].dut, cyc_cnt, got, sbq[i].exp);
                end
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_val(input int d, input int s, input int e, input string n);
        chk_t c;
        c.cyc = cyc_cnt; c.dut = d; c.sig = s; c.exp = e; c.name = n;
        sbq.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic en, input logic ud, input logic ra, input logic pa,
                       input logic we, input logic re, input logic db, input logic clr);
        b1.enable = en; b1.up_down = ud; b1.rst_adr = ra; b1.pr_res_adr = pa;
        b1.wr_en = we; b1.read_en = re; b1.data_bit = db; b1.clr_err = clr;
        b3.enable = en; b3.up_down = ud; b3.rst_adr = ra; b3.pr_res_adr = pa;
        b3.wr_en = we; b3.read_en = re; b3.data_bit = db; b3.clr_err = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();

        // Reset state, observed while rst_adr starts the write sweep.
        rst = 1'b0;
        drv(0, 0, 1, 0, 0, 0, 0, 0);
        expect_val(1, S_ADDR, 0, "rst_addr");
        expect_val(1, S_ERR, 0, "rst_error");
        expect_val(1, S_FADDR, 0, "rst_fail_addr");
        expect_val(1, S_FCNT, 0, "rst_fail_cnt");
        expect_val(1, S_BUSY, 0, "rst_busy");
        expect_val(1, S_COUT, 0, "rst_c_out");
        expect_val(3, S_BUSY, 0, "rst_busy3");
        step();

        // Write sweep up with data_bit=0.
        for (int k = 0; k < 16; k++) begin
            drv(1, 1, 0, 0, 1, 0, 0, 0);
            expect_val(1, S_ADDR, k, "wr_addr");
            expect_val(1, S_WE, 1, "wr_we");
            expect_val(1, S_RE, 0, "wr_re");
            expect_val(1, S_WDATA, 0, "wr_wdata");
            expect_val(1, S_COUT, (k == 15) ? 1 : 0, "wr_c_out");
            step();
        end

        // Up-count wrapped from 15 to 0; load all-ones for the read-down sweep.
        drv(0, 0, 0, 1, 0, 0, 0, 0);
        expect_val(1, S_ADDR, 0, "wrap_up_addr");
        step();

        // Clean read-down sweep.
        for (int k = 0; k < 16; k++) begin
            drv(1, 0, 0, 0, 0, 1, 0, 0);
            expect_val(1, S_ADDR, 15 - k, "rd_addr");
            expect_val(1, S_RE, 1, "rd_re");
            expect_val(1, S_WE, 0, "rd_we");
            expect_val(1, S_COUT, (k == 15) ? 1 : 0, "rd_c_out");
            expect_val(1, S_ERR, 0, "rd_error");
            expect_val(1, S_BUSY, (k > 0) ? 1 : 0, "rd_busy");
            step();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        expect_val(1, S_BUSY, 1, "rd_tail_busy");
        step();
        expect_val(1, S_BUSY, 0, "rd_idle_busy");
        expect_val(1, S_ERR, 0, "rd_idle_error");
        step();

        // Read-down sweep with faults at 9 and 3: first-fail capture.
        bad1 = 16'h0208;
        drv(0, 0, 0, 1, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 16; k++) begin
            drv(1, 0, 0, 0, 0, 1, 0, 0);
            if (k == 7) expect_val(1, S_ERR, 0, "ff_err_before");
            if (k == 8) begin
                expect_val(1, S_ERR, 1, "ff_err_rise");
                expect_val(1, S_FADDR, 9, "ff_fail_addr_first");
                expect_val(1, S_FCNT, 1, "ff_cnt_one");
            end
            if (k == 13) expect_val(1, S_FCNT, 1, "ff_cnt_before_second");
            if (k == 14) begin
                expect_val(1, S_FCNT, 2, "ff_cnt_two");
                expect_val(1, S_FADDR, 9, "ff_fail_addr_kept");
            end
            step();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        expect_val(1, S_ERR, 1, "ff_err_sticky");
        expect_val(1, S_FCNT, 2, "ff_cnt_final");
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        expect_val(1, S_ERR, 0, "clr_error");
        expect_val(1, S_FCNT, 0, "clr_fail_cnt");
        expect_val(1, S_FADDR, 0, "clr_fail_addr");
        bad1 = '0;
        step();

        // clr_err coincident with the mismatch for address 5 (6 already failed).
        bad1 = 16'h0060;
        drv(0, 0, 0, 1, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 16; k++) begin
            drv(1, 0, 0, 0, 0, 1, 0, (k == 11) ? 1'b1 : 1'b0);
            if (k == 10) expect_val(1, S_ERR, 0, "clrmm_err_before");
            if (k == 11) begin
                expect_val(1, S_ERR, 1, "clrmm_err_set");
                expect_val(1, S_FCNT, 1, "clrmm_cnt_one");
                expect_val(1, S_FADDR, 6, "clrmm_fail_addr");
            end
            if (k == 12) begin
                expect_val(1, S_ERR, 0, "clrmm_err_cleared");
                expect_val(1, S_FCNT, 0, "clrmm_cnt_cleared");
                expect_val(1, S_FADDR, 0, "clrmm_faddr_cleared");
            end
            if (k == 15) expect_val(1, S_ERR, 0, "clrmm_err_stays");
            step();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        bad1 = '0;
        step();

        // Count to 7, then rst_adr and pr_res_adr together.
        drv(0, 0, 1, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 7; k++) begin
            drv(1, 1, 0, 0, 0, 0, 0, 0);
            expect_val(1, S_ADDR, k, "cnt_addr");
            step();
        end
        drv(0, 0, 1, 1, 0, 0, 0, 0);
        expect_val(1, S_ADDR, 7, "both_pre_addr");
        step();
        drv(0, 0, 0, 1, 0, 0, 0, 0);
        expect_val(1, S_ADDR, 0, "both_rst_adr_wins");
        step();
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        expect_val(1, S_ADDR, 15, "pr_res_addr");
        expect_val(1, S_COUT, 0, "c_out_disabled");
        step();
        drv(1, 1, 0, 0, 0, 0, 0, 0);
        expect_val(1, S_COUT, 1, "c_out_up_top");
        step();
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        expect_val(1, S_ADDR, 0, "wrap_up_0");
        expect_val(1, S_COUT, 1, "c_out_down_zero");
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        expect_val(1, S_ADDR, 15, "wrap_down_15");
        step();

        // Latency-3 instance: up-sweep read with a fault at address 5.
        bad3 = 16'h0020;
        drv(0, 0, 1, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 16; k++) begin
            drv(1, 1, 0, 0, 0, 1, 0, 0);
            expect_val(3, S_ADDR, k, "l3_addr");
            if (k == 0) expect_val(3, S_BUSY, 0, "l3_busy_idle");
            if (k == 1) expect_val(3, S_BUSY, 1, "l3_busy_rise");
            if (k == 8) expect_val(3, S_ERR, 0, "l3_err_before");
            if (k == 9) begin
                expect_val(3, S_ERR, 1, "l3_err_rise");
                expect_val(3, S_FADDR, 5, "l3_fail_addr");
                expect_val(3, S_FCNT, 1, "l3_fail_cnt");
            end
            step();
        end
        for (int j = 16; j < 20; j++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0);
            expect_val(3, S_BUSY, (j <= 18) ? 1 : 0, "l3_busy_drain");
            if (j == 19) expect_val(1, S_ERR, 0, "l1_clean_up_read");
            step();
        end
        bad3 = '0;

        // rst mid-sweep with latency-3 reads in flight; address 14 would fail.
        bad3 = 16'h4000;
        drv(0, 0, 0, 1, 0, 0, 0, 0);
        step();
        drv(1, 0, 0, 0, 0, 1, 0, 0);
        expect_val(3, S_ADDR, 15, "mid_addr15");
        step();
        drv(1, 0, 0, 0, 0, 1, 0, 0);
        expect_val(3, S_BUSY, 1, "mid_busy_inflight");
        step();
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        expect_val(3, S_BUSY, 0, "mid_rst_busy3");
        expect_val(1, S_BUSY, 0, "mid_rst_busy1");
        expect_val(3, S_ADDR, 0, "mid_rst_addr");
        expect_val(3, S_ERR, 0, "mid_rst_err");
        step();
        for (int j = 0; j < 3; j++) begin
            expect_val(3, S_ERR, 0, "mid_no_stale_err");
            expect_val(3, S_FCNT, 0, "mid_no_stale_cnt");
            step();
        end
        tests_run++;
        if (b3.error !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_final_err3: got %0d, expected 0", b3.error);
        end
        tests_run++;
        if (b3.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_final_busy3: got %0d, expected 0", b3.busy);
        end
        bad3 = '0;

        step(); step();
        while (sbq.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unchecked_%s (dut%0d): expected %0d at cycle %0d, never sampled",
                     sbq[0].name, sbq[0].dut, sbq[0].exp, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/bist_datapath.md
Name: bist_datapath

Overview:
- Memory-BIST datapath stage directly downstream of the march-test controller.
- Consumes the controller's strobes (enable, up_down, rst_adr, pr_res_adr, wr_en, read_en, data_bit) and drives the memory under test.
- Returns the terminal-count flag c_out and a sticky error flag to the controller.
- Contains the up/down address counter, write-data generator, read-latency-matched compare pipeline, and first-fail capture logic.

Parameters:
- ADDR_W, 4: address width; the memory has 2^ADDR_W words.
- DATA_W, 8: memory word width.
- RD_LAT, 1: memory read latency in cycles, counted from the mem_re sampling edge to valid mem_rdata. Legal values are 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  counter and memory-access enable
- up_down  in  1  1 = increment address, 0 = decrement
- rst_adr  in  1  load address 0
- pr_res_adr  in  1  load address all-ones
- wr_en  in  1  write strobe request
- read_en  in  1  read strobe request
- data_bit  in  1  pattern bit, replicated across the word
- clr_err  in  1  clear error, fail_addr and fail_cnt
- mem_rdata  in  DATA_W  memory read data
- mem_addr  out  ADDR_W  memory address (equals the internal counter)
- mem_wdata  out  DATA_W  {DATA_W{data_bit}}
- mem_we  out  1  wr_en & enable
- mem_re  out  1  read_en & enable
- c_out  out  1  terminal count
- error  out  1  sticky mismatch flag
- fail_addr  out  ADDR_W  address of the first mismatch
- fail_cnt  out  8  mismatch count, saturating at 255
- busy  out  1  one or more reads in flight in the compare pipeline

Behaviour:
- Reset state (rst high at a clock edge): addr=0, all pipeline valid bits=0, error=0, fail_addr=0, fail_cnt=0.
- With addr=0 after reset: mem_addr=0; mem_we, mem_re and c_out follow their combinational equations.

Address counter, priority per edge:
- Priority order: rst > rst_adr > pr_res_adr > (enable ? count : hold).
- Count is +1 when up_down=1 and -1 when up_down=0. Both directions wrap modulo 2^ADDR_W.
- rst_adr and pr_res_adr load regardless of enable.
- If rst_adr and pr_res_adr are both high, rst_adr wins and addr becomes 0.

Terminal count (combinational, no register):
- c_out = enable & ((up_down & addr==all-ones) | (!up_down & addr==0)).
- c_out goes high in the same cycle the last address is presented, so the controller can switch state on that edge.

Memory drive (all combinational from inputs and the counter):
- mem_we and mem_re may both be high only if the controller drives both wr_en and read_en. The block does not arbitrate.

Compare pipeline:
- A shift register of depth RD_LAT; each stage holds {valid, expected bit, address}.
- Stage 0 loads {mem_re, data_bit, addr} at every edge.
- Each edge shifts the contents forward one stage. Entries are not dropped when enable falls.
- The final stage is aligned with mem_rdata.
- When the final stage is valid and mem_rdata != {DATA_W{expected}}, a mismatch occurs at that edge.
- On a mismatch:
  - error <= 1.
  - fail_cnt <= fail_cnt + 1, saturating at 255.
  - fail_addr <= stage address, but only if error was 0 before this edge (first fail only).
- Latency: a read issued at edge T compares mem_rdata during cycle T+RD_LAT; error is visible from cycle T+RD_LAT+1.

Flags:
- busy = OR of all pipeline valid bits.
- The controller must not return to standby and declare done while busy=1. This is the top-level integration rule.

clr_err:
- Synchronous. Clears error, fail_addr and fail_cnt.
- Takes priority over a mismatch at the same edge; the clear wins and that mismatch is lost.
- Does not affect addr or the pipeline.

Reset mid-test:
- Clears the pipeline as well, so no stale compare fires after reset.

Test Plan:
1. rst, then rst_adr=1 for one cycle, then enable=1, up_down=1, wr_en=1, data_bit=0 for 16 cycles -> mem_addr steps 0..15; mem_we=1 throughout; mem_wdata=0x00; c_out=1 only in the cycle with addr=15.
2. pr_res_adr=1, then enable=1, up_down=0, read_en=1, data_bit=0, with a model returning 0x00 (RD_LAT=1) -> addr steps 15..0; c_out=1 at addr=0; error stays 0; busy=1 until one cycle after the last read.
3. Same read-down sweep, with the model returning 0x10 at addresses 9 and 3 -> error rises in the cycle after addr 9's data; fail_addr=9 (not 3); fail_cnt=2.
4. Run with RD_LAT=3 and a single mismatch at address 5 during the up-sweep read -> error first seen 4 cycles after the mem_re edge for addr 5; fail_addr=5.
5. rst_adr=1 and pr_res_adr=1 together at addr=7 -> addr=0. Separately, enable=1, up_down=1 at addr=15 -> wraps to 0.
6. clr_err=1 coincident with a mismatch -> error=0 and fail_cnt=0 next cycle. Separately, rst asserted mid-read-sweep with reads in flight -> busy=0 next cycle and no error afterwards.
